// File: rtl/sort4_ctrl_if.sv
// Load/output handshake bundle for sort4_ctrl. The master side is the
// producer/consumer environment and the slave side is the sorter.
interface sort4_ctrl_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: loads four 4-bit values, bubble-sorts them in place through one
// shared comparator, then streams them out in ascending order.
module sort4_cmp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       equality,
    output logic       a_greater,
    output logic       b_greater
);
    assign equality  = (a == b);
    assign a_greater = (a > b);
    assign b_greater = (a < b);
endmodule

module sort4_ctrl (
    input  logic        clk,
    input  logic        rst,
    sort4_ctrl_if.slave bus,
    output logic        busy,
    output logic [2:0]  swap_count
);
    typedef enum logic [1:0] {LOAD = 2'd0, SORT = 2'd1, OUT = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [3:0][3:0] r_q, r_d;
    logic [1:0]      lcnt_q, lcnt_d;
    logic [1:0]      ocnt_q, ocnt_d;
    logic [1:0]      pass_q, pass_d;
    logic [1:0]      idx_q, idx_d;
    logic            swapped_q, swapped_d;
    logic [2:0]      swap_count_q, swap_count_d;

    logic [1:0] idx_nx;
    logic [3:0] cmp_a, cmp_b;
    logic       cmp_eq, cmp_a_gt, cmp_b_gt;
    logic       do_swap, last_cmp;

    logic       in_ready_o, out_valid_o, out_last_o, busy_o;
    logic [3:0] out_data_o;

    assign idx_nx = idx_q + 2'd1;
    assign cmp_a  = r_q[idx_q];
    assign cmp_b  = r_q[idx_nx];

    sort4_cmp u_cmp (
        .a         (cmp_a),
        .b         (cmp_b),
        .equality  (cmp_eq),
        .a_greater (cmp_a_gt),
        .b_greater (cmp_b_gt)
    );

    // Equal or B-greater pairs keep their order, which keeps the sort stable.
    assign do_swap  = cmp_a_gt & ~(cmp_eq | cmp_b_gt);
    assign last_cmp = (idx_q == (2'd2 - pass_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            r_q          <= '0;
            lcnt_q       <= 2'd0;
            ocnt_q       <= 2'd0;
            pass_q       <= 2'd0;
            idx_q        <= 2'd0;
            swapped_q    <= 1'b0;
            swap_count_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            lcnt_q       <= lcnt_d;
            ocnt_q       <= ocnt_d;
            pass_q       <= pass_d;
            idx_q        <= idx_d;
            swapped_q    <= swapped_d;
            swap_count_q <= swap_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        lcnt_d       = lcnt_q;
        ocnt_d       = ocnt_q;
        pass_d       = pass_q;
        idx_d        = idx_q;
        swapped_d    = swapped_q;
        swap_count_d = swap_count_q;
        case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    r_d[lcnt_q] = bus.in_data;
                    lcnt_d      = lcnt_q + 2'd1;
                    if (lcnt_q == 2'd3) begin
                        state_d      = SORT;
                        pass_d       = 2'd0;
                        idx_d        = 2'd0;
                        swapped_d    = 1'b0;
                        swap_count_d = 3'd0;
                    end
                end
            end
            SORT: begin
                if (do_swap) begin
                    r_d[idx_q]   = r_q[idx_nx];
                    r_d[idx_nx]  = r_q[idx_q];
                    swapped_d    = 1'b1;
                    swap_count_d = swap_count_q + 3'd1;
                end
                // A pass without any swap (this compare included) means sorted.
                if (last_cmp) begin
                    if (pass_q == 2'd2 || !(swapped_q || do_swap)) begin
                        state_d = OUT;
                        ocnt_d  = 2'd0;
                    end else begin
                        pass_d    = pass_q + 2'd1;
                        idx_d     = 2'd0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_nx;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (ocnt_q == 2'd3) begin
                        state_d = LOAD;
                        lcnt_d  = 2'd0;
                        ocnt_d  = 2'd0;
                    end else begin
                        ocnt_d = ocnt_q + 2'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Status outputs are forced low while reset is held.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        busy_o      = 1'b0;
        out_data_o  = r_q[ocnt_q];
        if (!rst) begin
            in_ready_o  = (state_q == LOAD);
            busy_o      = (state_q == SORT);
            out_valid_o = (state_q == OUT);
            out_last_o  = (state_q == OUT) && (ocnt_q == 2'd3);
        end
    end

    assign bus.in_ready  = in_ready_o;
    assign bus.out_valid = out_valid_o;
    assign bus.out_last  = out_last_o;
    assign bus.out_data  = out_data_o;
    assign busy          = busy_o;
    assign swap_count    = swap_count_q;
endmodule

// File: tb/tb_sort4_ctrl.sv
// Self-checking bench for sort4_ctrl: directed vector table, reset corner
// sequences and randomized loads checked against a stable-sort reference model.
module tb_sort4_ctrl;
    logic       clk;
    logic       rst;
    logic       busy;
    logic [2:0] swap_count;
    int         checks;
    int         errors;

    sort4_ctrl_if bus ();

    sort4_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .swap_count (swap_count)
    );

    typedef struct {
        logic [3:0][3:0] vin;
        logic [3:0][3:0] vout;
        int              swaps;
        int              cyc;
        int              stall;
    } vec_t;

    vec_t table_v [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Values are written first-loaded in the top nibble.
    function automatic vec_t make_vec(input logic [15:0] vin, input logic [15:0] vout,
                                      input int swaps, input int cyc, input int stall);
        vec_t m;
        for (int i = 0; i < 4; i++) begin
            m.vin[i]  = vin[15-4*i -: 4];
            m.vout[i] = vout[15-4*i -: 4];
        end
        m.swaps = swaps;
        m.cyc   = cyc;
        m.stall = stall;
        return m;
    endfunction

    // Swaps = inversion count; passes run = 1 + largest count of bigger values
    // to the left of any element, capped at three passes of 3, 2, 1 compares.
    function automatic vec_t ref_model(input logic [3:0][3:0] v, input int stall);
        vec_t m;
        int   left, maxleft, rank;
        m.vin   = v;
        m.swaps = 0;
        maxleft = 0;
        for (int j = 0; j < 4; j++) begin
            left = 0;
            rank = 0;
            for (int i = 0; i < 4; i++) begin
                if (i < j && v[i] > v[j]) left++;
                if (v[i] < v[j] || (v[i] == v[j] && i < j)) rank++;
            end
            m.vout[rank] = v[j];
            m.swaps += left;
            if (left > maxleft) maxleft = left;
        end
        m.cyc   = (maxleft == 0) ? 3 : (maxleft == 1) ? 5 : 6;
        m.stall = stall;
        return m;
    endfunction

    task automatic load_n(input logic [3:0][3:0] vals, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            check_output("in_ready_load", {7'd0, bus.in_ready}, 8'd1);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_sort(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin
            bus.in_data = 4'($urandom);
            cyc++;
            tick();
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input bit noisy);
        int cyc;
        load_n(v.vin, 4);
        bus.in_valid = noisy;
        check_output("in_ready_sort", {7'd0, bus.in_ready}, 8'd0);
        wait_sort(cyc);
        check_output("busy_cycles", 8'(cyc), 8'(v.cyc));
        check_output("swap_count", {5'd0, swap_count}, 8'(v.swaps));
        for (int k = 0; k < 4; k++) begin
            bus.out_ready = 1'b0;
            for (int s = 0; s < ((k == 0) ? v.stall : 0); s++) begin
                check_output("stall_valid", {7'd0, bus.out_valid}, 8'd1);
                check_output("stall_data", {4'd0, bus.out_data}, {4'd0, v.vout[0]});
                tick();
            end
            bus.out_ready = 1'b1;
            if (k == 3) bus.in_valid = 1'b0;
            check_output("out_valid", {7'd0, bus.out_valid}, 8'd1);
            check_output("out_data", {4'd0, bus.out_data}, {4'd0, v.vout[k]});
            check_output("out_last", {7'd0, bus.out_last}, (k == 3) ? 8'd1 : 8'd0);
            tick();
        end
        bus.out_ready = 1'b0;
        check_output("in_ready_after", {7'd0, bus.in_ready}, 8'd1);
        check_output("out_valid_after", {7'd0, bus.out_valid}, 8'd0);
        check_output("swap_count_hold", {5'd0, swap_count}, 8'(v.swaps));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_output("rst_in_ready", {7'd0, bus.in_ready}, 8'd0);
        check_output("rst_busy", {7'd0, busy}, 8'd0);
        check_output("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check_output("rst_out_last", {7'd0, bus.out_last}, 8'd0);
        tick();
        rst = 1'b0;
        #1;
        check_output("post_rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check_output("post_rst_busy", {7'd0, busy}, 8'd0);
        check_output("post_rst_swap_count", {5'd0, swap_count}, 8'd0);
        check_output("post_rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    endtask

    initial begin
        int   cyc;
        vec_t v;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.out_ready = 1'b0;

        table_v[0] = make_vec(16'hC43A, 16'h34AC, 4, 6, 0);
        table_v[1] = make_vec(16'h037F, 16'h037F, 0, 3, 0);
        table_v[2] = make_vec(16'hFB70, 16'h07BF, 6, 6, 0);
        table_v[3] = make_vec(16'h7707, 16'h0777, 2, 6, 0);
        table_v[4] = make_vec(16'hC43A, 16'h34AC, 4, 6, 5);
        table_v[5] = make_vec(16'h1023, 16'h0123, 1, 5, 0);

        tick();
        pulse_reset();

        for (int t = 0; t < 6; t++) apply_stimulus(table_v[t], 1'b0);

        // Reset in the second SORT cycle, then a fresh load must sort cleanly.
        load_n(table_v[0].vin, 4);
        check_output("mid_sort_busy", {7'd0, busy}, 8'd1);
        tick();
        check_output("mid_sort_swaps", {5'd0, swap_count}, 8'd1);
        pulse_reset();
        apply_stimulus(make_vec(16'h2103, 16'h0123, 3, 6, 0), 1'b0);

        // Partial load discarded by reset.
        load_n(table_v[2].vin, 2);
        pulse_reset();
        apply_stimulus(table_v[3], 1'b1);

        // Reset in the middle of the output stream.
        load_n(table_v[2].vin, 4);
        wait_sort(cyc);
        bus.out_ready = 1'b1;
        tick();
        check_output("mid_out_data", {4'd0, bus.out_data}, 8'd7);
        bus.out_ready = 1'b0;
        pulse_reset();

        for (int r = 0; r < 40; r++) begin
            logic [3:0][3:0] vin;
            for (int i = 0; i < 4; i++) vin[i] = 4'($urandom_range(0, 15));
            v = ref_model(vin, int'($urandom_range(0, 3)));
            apply_stimulus(v, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-004 SHALL have port in_data, input, 4 bits: unsigned value to load.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a load this cycle.
REQ-006 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-007 SHALL have port out_data, output, 4 bits: sorted value, ascending order.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-009 SHALL have port out_last, output, 1 bit: out_data is the 4th (largest) value.
REQ-010 SHALL have port busy, output, 1 bit: high while in SORT.
REQ-011 SHALL have port swap_count, output, 3 bits: number of swaps performed in the last sort.

Function
REQ-012 SHALL hold four 4-bit registers r0..r3 and instantiate exactly one comparator (4-bit A, B; outputs Equality, A_greater, B_greater), shared across all compare steps.
REQ-013 SHALL implement the FSM states LOAD, SORT and OUT, with in_ready = (state==LOAD), busy = (state==SORT) and out_valid = (state==OUT).
REQ-014 LOAD SHALL write in_data into r[lcnt] and increment the 2-bit lcnt on each in_valid&&in_ready; on the 4th accept it SHALL go to SORT with pass=0, idx=0, swapped=0 and swap_count=0.
REQ-015 SHALL ignore in_valid and in_data outside LOAD, with no register change.
REQ-016 Each SORT cycle SHALL drive comparator A=r[idx] and B=r[idx+1], and SHALL swap the pair at the clock edge if A_greater=1, also setting swapped=1 and incrementing swap_count.
REQ-017 SHALL NOT swap on Equality or B_greater, so the sort is stable.
REQ-018 The last compare of a pass SHALL be idx==2-pass.
REQ-019 At the last compare of a pass, SHALL go to OUT if pass==2, or if no swap occurred in the pass including the current cycle; otherwise SHALL increment pass and set idx=0, swapped=0.
REQ-020 Sort latency SHALL be 3 cycles minimum (already sorted input) and 6 cycles maximum.
REQ-021 OUT SHALL present out_data=r[ocnt] starting at ocnt=0, with out_last=(ocnt==3).
REQ-022 OUT SHALL increment ocnt on out_valid&&out_ready and SHALL hold out_data stable while out_ready=0.
REQ-023 The handshake with out_last=1 SHALL return the FSM to LOAD with lcnt=0 and ocnt=0.
REQ-024 swap_count SHALL stay stable from SORT exit until the next SORT entry.

Reset
REQ-025 rst=1 at a clock edge SHALL set state=LOAD; lcnt, ocnt, pass, idx and swapped to 0; r0..r3 to 0; and swap_count to 0, regardless of the current state (mid-load, mid-sort or mid-output).
REQ-026 While rst is high, in_ready, out_valid, out_last and busy SHALL be 0; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 No partial load, sort or output SHALL survive reset.

Verification
REQ-028 Load C,4,3,A -> out 3,4,A,C; out_last on A... on C only; swap_count=4; busy high for 6 cycles.
REQ-029 Load 0,3,7,F -> out 0,3,7,F; swap_count=0; busy high for 3 cycles.
REQ-030 Load F,B,7,0 -> out 0,7,B,F; swap_count=6; busy high for 6 cycles.
REQ-031 Load 7,7,0,7 -> out 0,7,7,7; swap_count=2; busy high for 6 cycles.
REQ-032 Load C,4,3,A with out_ready=0 for 5 cycles in OUT -> out_data held at 3 and out_valid held at 1; then out_ready=1 -> 4,A,C on consecutive cycles.
REQ-033 rst pulsed during the 2nd SORT cycle -> next cycle in_ready=1, busy=0, swap_count=0; a fresh load of 2,1,0,3 -> out 0,1,2,3.
